// File: rtl/ecc_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ecc_mem_ctrl: ECC array port arbiter, host/scrub, corrected write-back    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ecc_mem_ctrl #(
  parameter int AW             = 4,
  parameter int DW             = 8,
  parameter int SCRUB_INTERVAL = 64,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             host_req,
  input  logic             host_we,
  input  logic [AW-1:0]    host_addr,
  input  logic [DW-1:0]    host_wdata,
  output logic             host_ack,
  output logic [DW-1:0]    host_rdata,
  output logic             host_err,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_we,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  input  logic             mem_err,
  input  logic             scrub_en,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_count,
  output logic             busy
);

  localparam int            TW         = $clog2(SCRUB_INTERVAL);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SCRUB_INTERVAL - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    H_WR  = 3'd1,
    H_RD  = 3'd2,
    H_RDW = 3'd3,
    S_RD  = 3'd4,
    S_RDW = 3'd5,
    WB    = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    maddr_q, maddr_d;
  logic             mwe_q, mwe_d;
  logic [DW-1:0]    mwdata_q, mwdata_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             herr_q, herr_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    maddr_d  = maddr_q;
    mwe_d    = 1'b0;
    mwdata_d = mwdata_q;
    rdata_d  = rdata_q;
    herr_d   = herr_q;
    ptr_d    = ptr_q;
    timer_d  = timer_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;

    // mem_addr stays put through the read-wait state, so WB reuses it
    case (state_q)
      IDLE: begin
        if (host_req) begin
          maddr_d = host_addr;
          if (host_we) begin
            state_d  = H_WR;
            mwe_d    = 1'b1;
            mwdata_d = host_wdata;
          end else begin
            state_d = H_RD;
          end
        end else if (pend_q) begin
          pend_d  = 1'b0;
          maddr_d = ptr_q;
          state_d = S_RD;
        end
      end
      H_WR:  state_d = IDLE;
      H_RD:  state_d = H_RDW;
      H_RDW: begin
        rdata_d = mem_rdata;
        herr_d  = mem_err;
        if (mem_err) begin
          state_d  = WB;
          mwe_d    = 1'b1;
          mwdata_d = mem_rdata;
        end else begin
          state_d = IDLE;
        end
      end
      S_RD:  state_d = S_RDW;
      S_RDW: begin
        ptr_d = ptr_q + 1'b1;
        if (mem_err) begin
          state_d  = WB;
          mwe_d    = 1'b1;
          mwdata_d = mem_rdata;
        end else begin
          state_d = IDLE;
        end
      end
      WB: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A fresh expiry overrides the dispatch clear in the same cycle
    if (scrub_en) begin
      if (timer_q == TIMER_LAST) begin
        timer_d = '0;
        pend_d  = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end

    if (err_clr) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      maddr_q  <= '0;
      mwe_q    <= 1'b0;
      mwdata_q <= '0;
      rdata_q  <= '0;
      herr_q   <= 1'b0;
      ptr_q    <= '0;
      timer_q  <= '0;
      pend_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      maddr_q  <= maddr_d;
      mwe_q    <= mwe_d;
      mwdata_q <= mwdata_d;
      rdata_q  <= rdata_d;
      herr_q   <= herr_d;
      ptr_q    <= ptr_d;
      timer_q  <= timer_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
    end
  end

  // Read data bypasses the holding register during the ack cycle
  assign host_ack   = (state_q == H_WR) || (state_q == H_RDW);
  assign host_rdata = (state_q == H_RDW) ? mem_rdata : rdata_q;
  assign host_err   = (state_q == H_RDW) ? mem_err : herr_q;
  assign mem_addr   = maddr_q;
  assign mem_we     = mwe_q;
  assign mem_wdata  = mwdata_q;
  assign err_count  = cnt_q;
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ecc_mem_ctrl.sv
`default_nettype none
// Bench for ecc_mem_ctrl: synchronous array model with per-word error flags
// plus queue scoreboards for host read responses and array writes.
module tb_ecc_mem_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int SI = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          host_req = 1'b0, host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_ack, host_err, mem_we, busy;
  logic [DW-1:0] host_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          mem_err;
  logic          scrub_en = 1'b0, err_clr = 1'b0;
  logic [CW-1:0] err_count;

  logic          bd_we = 1'b0, bd_err = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;
  bit   [DW-1:0] mem_arr [2**AW];
  bit            err_arr [2**AW];

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct packed { logic [DW-1:0] d; logic e; } rd_t;
  wr_t exp_wr[$];
  wr_t obs_wr[$];
  rd_t exp_rd[$];
  int  checks = 0;
  int  failures = 0;

  always #5 clk = ~clk;

  ecc_mem_ctrl #(.AW(AW), .DW(DW), .SCRUB_INTERVAL(SI), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_err(host_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_err(mem_err),
    .scrub_en(scrub_en), .err_clr(err_clr), .err_count(err_count), .busy(busy)
  );

  // Array returns corrected data; a write repairs the flagged word
  always @(posedge clk) begin
    mem_rdata <= mem_arr[mem_addr];
    mem_err   <= err_arr[mem_addr];
    if (mem_we) begin
      mem_arr[mem_addr] <= mem_wdata;
      err_arr[mem_addr] <= 1'b0;
    end
    if (bd_we) begin
      mem_arr[bd_addr] <= bd_data;
      err_arr[bd_addr] <= bd_err;
    end
  end

  always @(negedge clk) if (rst_n && mem_we) obs_wr.push_back({mem_addr, mem_wdata});

  task automatic backdoor(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e);
    bd_we = 1'b1; bd_addr = a; bd_data = d; bd_err = e;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic host_xfer(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input bit scramble, output int lat,
                           output logic [DW-1:0] rd, output logic er);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = wd;
    lat = 0; rd = 'x; er = 1'bx;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (host_ack) begin
        rd = host_rdata; er = host_err;
        break;
      end
      if (scramble) begin
        host_addr = AW'($urandom); host_wdata = DW'($urandom);
      end
    end
    if (!host_ack) lat = -1;
    host_req = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      host_req = 1'($urandom); host_we = 1'($urandom);
      host_addr = AW'($urandom); host_wdata = DW'($urandom);
      scrub_en = 1'($urandom); err_clr = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({host_ack, host_err, mem_we, busy, host_rdata, mem_addr, mem_wdata, err_count} !== '0) begin
        failures++;
        $display("FAIL reset_outputs i=%0d ack=%b err=%b we=%b busy=%b rdata=%h addr=%h wdata=%h cnt=%h want all 0",
                 i, host_ack, host_err, mem_we, busy, host_rdata, mem_addr, mem_wdata, err_count);
      end
    end
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    scrub_en = 1'b0; err_clr = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle cycle=%0d mem_we=%b busy=%b want 0 0", i, mem_we, busy);
      end
    end
  endtask

  task automatic check_writes(input string tag);
    wr_t we_, wo_;
    checks++;
    if (obs_wr.size() != exp_wr.size()) begin
      failures++;
      $display("FAIL %s_wr_count got=%0d want=%0d", tag, obs_wr.size(), exp_wr.size());
    end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      we_ = exp_wr.pop_front();
      wo_ = obs_wr.pop_front();
      checks++;
      if (wo_ !== we_) begin
        failures++;
        $display("FAIL %s_wr addr/data got=%h/%h want=%h/%h", tag, wo_.a, wo_.d, we_.a, we_.d);
      end
    end
    exp_wr.delete();
    obs_wr.delete();
  endtask

  task automatic check_read(input string tag, input int lat, input int want_lat,
                            input logic [DW-1:0] rd, input logic er);
    rd_t r;
    r = exp_rd.pop_front();
    checks++;
    if (lat != want_lat) begin
      failures++;
      $display("FAIL %s_latency got=%0d want=%0d", tag, lat, want_lat);
    end
    checks++;
    if (rd !== r.d || er !== r.e) begin
      failures++;
      $display("FAIL %s_data rdata/err got=%h/%b want=%h/%b", tag, rd, er, r.d, r.e);
    end
  endtask

  task automatic test_write_read;
    int lat; logic [DW-1:0] rd; logic er;
    exp_wr.push_back({4'd3, 8'hA5});
    host_xfer(1'b1, 4'd3, 8'hA5, 1'b1, lat, rd, er);
    checks++;
    if (lat != 1) begin
      failures++; $display("FAIL wr_latency got=%0d want=1", lat);
    end
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 4'd3, 8'hA5}) begin
      failures++;
      $display("FAIL wr_port we/addr/wdata got=%b/%h/%h want=1/3/a5", mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    exp_rd.push_back({8'hA5, 1'b0});
    host_xfer(1'b0, 4'd3, 8'h00, 1'b1, lat, rd, er);
    check_read("rd_clean", lat, 2, rd, er);
    repeat (3) @(negedge clk);
    check_writes("write_read");
  endtask

  task automatic test_read_err;
    int lat; logic [DW-1:0] rd; logic er;
    backdoor(4'd7, 8'h3C, 1'b1);
    exp_rd.push_back({8'h3C, 1'b1});
    exp_wr.push_back({4'd7, 8'h3C});
    host_xfer(1'b0, 4'd7, 8'h00, 1'b1, lat, rd, er);
    check_read("rd_err", lat, 2, rd, er);
    @(negedge clk);
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 4'd7, 8'h3C}) begin
      failures++;
      $display("FAIL wb_port we/addr/wdata got=%b/%h/%h want=1/7/3c", mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    checks++;
    if (err_count !== 2'd1) begin
      failures++; $display("FAIL wb_count got=%0d want=1", err_count);
    end
    check_writes("read_err");
  endtask

  task automatic test_scrub;
    int exp_sa[$];
    int sa, last, found;
    logic prev_busy;
    backdoor(4'd5, 8'h5A, 1'b1);
    for (int k = 0; k < 20; k++) exp_sa.push_back(k % 16);
    exp_wr.push_back({4'd5, 8'h5A});
    scrub_en = 1'b1; prev_busy = 1'b0; last = -1; found = 0;
    for (int cyc = 1; cyc <= 90; cyc++) begin
      @(negedge clk);
      if (busy && !prev_busy) begin
        found++;
        sa = exp_sa.pop_front();
        checks++;
        if (int'(mem_addr) != sa || mem_we !== 1'b0) begin
          failures++;
          $display("FAIL scrub_addr n=%0d got=%0d we=%b want=%0d we=0", found, mem_addr, mem_we, sa);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != SI) begin
            failures++; $display("FAIL scrub_gap n=%0d got=%0d want=%0d", found, cyc - last, SI);
          end
        end
        last = cyc;
      end
      prev_busy = busy;
      if (found == 20) break;
    end
    scrub_en = 1'b0;
    checks++;
    if (found != 20) begin
      failures++; $display("FAIL scrub_count got=%0d want=20", found);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (err_count !== 2'd2) begin
      failures++; $display("FAIL scrub_err_count got=%0d want=2", err_count);
    end
    check_writes("scrub");
  endtask

  task automatic test_collision;
    int lat; logic [DW-1:0] rd; logic er;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // Enable; the fourth edge sets pending just as the host request arrives
    scrub_en = 1'b1;
    repeat (SI) @(negedge clk);
    exp_wr.push_back({4'd9, 8'h99});
    host_xfer(1'b1, 4'd9, 8'h99, 1'b0, lat, rd, er);
    checks++;
    if (lat != 1) begin
      failures++; $display("FAIL coll_host_first latency got=%0d want=1", lat);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL coll_gap busy got=%b want=0", busy);
    end
    @(negedge clk);
    scrub_en = 1'b0;
    checks++;
    if ({busy, mem_we, mem_addr} !== {1'b1, 1'b0, 4'd0}) begin
      failures++;
      $display("FAIL coll_scrub_next busy/we/addr got=%b/%b/%h want=1/0/0", busy, mem_we, mem_addr);
    end
    repeat (3) @(negedge clk);
    backdoor(4'd1, 8'h11, 1'b1);
    exp_wr.push_back({4'd1, 8'h11});
    scrub_en = 1'b1;
    @(negedge clk);
    scrub_en = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || mem_addr !== 4'd1) begin
      failures++; $display("FAIL coll_in_scrub busy/addr got=%b/%h want=1/1", busy, mem_addr);
    end
    exp_rd.push_back({8'h99, 1'b0});
    host_xfer(1'b0, 4'd9, 8'h00, 1'b0, lat, rd, er);
    check_read("coll_wait", lat, 4, rd, er);
    repeat (2) @(negedge clk);
    checks++;
    if (err_count !== 2'd1) begin
      failures++; $display("FAIL coll_err_count got=%0d want=1", err_count);
    end
    check_writes("collision");
  endtask

  task automatic test_saturate_clear;
    int lat; logic [DW-1:0] rd; logic er;
    logic [AW-1:0] a; logic [DW-1:0] d;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (err_count !== 2'd0) begin
      failures++; $display("FAIL clr_count got=%0d want=0", err_count);
    end
    for (int k = 0; k < 5; k++) begin
      a = AW'(10 + k); d = DW'(8'h20 + k * 8'h11);
      backdoor(a, d, 1'b1);
      exp_rd.push_back({d, 1'b1});
      exp_wr.push_back({a, d});
      host_xfer(1'b0, a, 8'h00, 1'b1, lat, rd, er);
      check_read("sat_rd", lat, 2, rd, er);
      repeat (2) @(negedge clk);
    end
    checks++;
    if (err_count !== 2'd3) begin
      failures++; $display("FAIL sat_count got=%0d want=3", err_count);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    backdoor(4'd12, 8'hC3, 1'b1);
    exp_rd.push_back({8'hC3, 1'b1});
    exp_wr.push_back({4'd12, 8'hC3});
    host_xfer(1'b0, 4'd12, 8'h00, 1'b0, lat, rd, er);
    check_read("clr_rd", lat, 2, rd, er);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (err_count !== 2'd0) begin
      failures++; $display("FAIL clr_vs_wb got=%0d want=0", err_count);
    end
    check_writes("saturate");

    backdoor(4'd15, 8'hF0, 1'b1);
    host_req = 1'b1; host_we = 1'b0; host_addr = 4'd15;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    host_req = 1'b0;
    #1;
    checks++;
    if ({host_ack, mem_we, busy} !== 3'b000) begin
      failures++;
      $display("FAIL rst_mid ack/we/busy got=%b/%b/%b want=0/0/0", host_ack, mem_we, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({host_ack, mem_we, busy} !== 3'b000) begin
        failures++;
        $display("FAIL rst_after i=%0d ack/we/busy got=%b/%b/%b want=0/0/0", i, host_ack, mem_we, busy);
      end
    end
    check_writes("rst_mid");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_read_err();
    test_scrub();
    test_collision();
    test_saturate_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/ecc_mem_ctrl.md
Name: ecc_mem_ctrl

Overview:
Controller for a word-organised array of ECC-protected storage cells. It arbitrates one memory port between a host requester and a background scrub engine. Any read that reports a corrected error is written back with the corrected data. Corrected errors are counted. Sits between the CPU-side bus and the ECC memory array.

Parameters:
AW, 4, address width; array depth = 2^AW words
DW, 8, data word width
SCRUB_INTERVAL, 64, cycles between scrub requests (>= 2)
CNT_W, 8, width of corrected-error counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
host_req  input  1  host request; sampled only in IDLE
host_we  input  1  1 = write, 0 = read; qualified by host_req
host_addr  input  AW  host address
host_wdata  input  DW  host write data
host_ack  output  1  one-cycle completion pulse
host_rdata  output  DW  read data; valid with host_ack on reads, held until next read ack
host_err  output  1  corrected error seen on this read; valid with host_ack
mem_addr  output  AW  array address
mem_we  output  1  array write enable
mem_wdata  output  DW  array write data
mem_rdata  input  DW  array read data, already corrected; valid 1 cycle after address with mem_we=0
mem_err  input  1  corrected-error flag; timing same as mem_rdata
scrub_en  input  1  enables scrub timer
err_clr  input  1  synchronous clear of err_count
err_count  output  CNT_W  saturating corrected-error count
busy  output  1  state != IDLE

Behaviour:
- Reset: state IDLE; host_ack, host_rdata, host_err, mem_addr, mem_we, mem_wdata, err_count, scrub pointer, timer and pending flag all 0. Reset asserted mid-operation abandons the operation, forces mem_we=0 immediately and issues no ack.
- States: IDLE, H_WR, H_RD, H_RDW, S_RD, S_RDW, WB. mem_* outputs come from registered state and registers only.
- IDLE:
  - If host_req=1, latch addr, we and wdata, then go to H_WR or H_RD.
  - Else if scrub pending, clear pending and go to S_RD.
  - Host has strict priority at this decision point.
- H_WR: mem_we=1, mem_addr=addr_q, mem_wdata=wdata_q. host_ack=1 in this same cycle. Next state IDLE.
- H_RD: mem_addr=addr_q, mem_we=0. Next state H_RDW.
- H_RDW:
  - Sample mem_rdata and mem_err into host_rdata and host_err; host_ack=1.
  - If mem_err=1, latch data and go to WB; else go to IDLE.
  - Latency: write ack 1 cycle after acceptance; read ack 2 cycles after acceptance.
- S_RD: mem_addr=scrub_ptr. Next state S_RDW.
- S_RDW:
  - Sample mem_rdata and mem_err.
  - scrub_ptr increments and wraps 2^AW-1 to 0.
  - If mem_err=1, go to WB with the address held; else go to IDLE.
  - host_* outputs are untouched.
- WB: mem_we=1, mem_addr = address just read, mem_wdata = corrected data. err_count increments. Next state IDLE.
- Scrub and write-back sequences are never preempted. A host_req arriving during them waits, held high, until IDLE.
- Host protocol:
  - host_req is held until host_ack.
  - host_req still high in the IDLE cycle after ack is a new request.
  - Inputs are latched at acceptance; later changes are ignored.
- Scrub timer:
  - Counts while scrub_en=1; holds when scrub_en=0.
  - At SCRUB_INTERVAL-1 it sets pending and wraps to 0.
  - An expiry while pending is already set is absorbed; there is no queueing.
  - scrub_en=0 does not clear an existing pending flag.
- err_count saturates at 2^CNT_W-1. err_clr=1 forces 0 and wins over a simultaneous increment.

Test Plan:
1. Reset: hold rst_n=0 with random inputs -> all outputs 0. Release with no requests and scrub_en=0 -> stays IDLE, mem_we never 1.
2. Host write addr 3, data 0xA5 -> next cycle mem_we=1, mem_addr=3, mem_wdata=0xA5, host_ack=1. Then host read addr 3 with model returning 0xA5 and err 0 -> ack 2 cycles after acceptance, host_rdata=0xA5, host_err=0, no WB.
3. Host read addr 7, model returns 0x3C with mem_err=1 -> host_ack with host_rdata=0x3C and host_err=1. Next cycle mem_we=1, mem_addr=7, mem_wdata=0x3C. err_count=1.
4. SCRUB_INTERVAL=4, scrub_en=1, no host traffic -> S_RD issues addr 0, 1, 2, … every 4 cycles and wraps 15 to 0. Error injected on addr 5 -> WB to addr 5, err_count increments.
5. Collision:
   - host_req in the same cycle pending is set -> host is served first, scrub follows immediately after.
   - host_req raised during S_RDW -> ack arrives only after the scrub (and WB, if any) completes.
6. CNT_W=2 with 5 injected errors -> err_count=3. err_clr coincident with a WB -> 0. Reset asserted during H_RDW -> mem_we=0, no host_ack, state IDLE.
